uart_mem_host: RTL
==================

// Module: uart_mem_host
// PURPOSE
//  Host-side bus master for the serial memory target. Accepts parallel read/write
//  requests over a valid/ready port and serialises them into UART frames on tx:
//  write = {cmd=1, addr, data}; read = {cmd=0, addr}. For reads it deserialises the
//  target's single reply frame on rx and returns it on a one-cycle response strobe.
//  Sits directly upstream of the target: host.tx -> target.RX, target.TX -> host.rx.
// PARAMETERS
//  ADDR_WIDTH     8    frame payload width; address width. Every frame carries ADDR_WIDTH bits
//  DATA_WIDTH     4    memory word width; must be <= ADDR_WIDTH (elaboration $fatal otherwise)
//  BAUD_PERIOD    4    clk cycles per serial bit; must be >= 2 (elaboration $fatal otherwise)
//  GAP_BITS       2    idle-high bit times inserted between consecutive frames of one request
//  TIMEOUT_CYC    1024 clk cycles to wait for a read-reply start bit before giving up
// PORTS
//  clk          in   1           clock
//  rst_l        in   1           reset; asynchronous, active-low
//  req_valid    in   1           request present
//  req_ready    out  1           high only in IDLE; transfer on req_valid & req_ready
//  req_write    in   1           1 = write, 0 = read
//  req_addr     in   ADDR_WIDTH  target address
//  req_wdata    in   DATA_WIDTH  write data (ignored for reads)
//  rsp_valid    out  1           one-cycle pulse: request complete
//  rsp_rdata    out  DATA_WIDTH  read data (0 for writes, timeouts, framing errors)
//  rsp_err      out  1           qualifies rsp_valid: reply timeout or bad stop bit
//  busy         out  1           ~req_ready
//  tx           out  1           serial out to target RX; idle high
//  rx           in   1           serial in from target TX; idle high
// BEHAVIOUR
//  Reset: tx=1, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE.
//  Frame format: start bit(0), ADDR_WIDTH payload bits LSB first, stop bit(1); each bit
//   is driven for exactly BAUD_PERIOD cycles. Frame length is (ADDR_WIDTH+2)*BAUD_PERIOD.
//  Request capture: on the accept edge, req_write/addr/wdata are registered. Ports may
//   then change. tx start bit begins the cycle after acceptance.
//  Cmd frame payload = {ADDR_WIDTH-1 zeros, req_write}. Data frame = zero-extended wdata.
//  FSM: IDLE -> SEND_CMD -> GAP -> SEND_ADDR -> (write: GAP -> SEND_DATA -> DONE)
//                                           -> (read: WAIT_RSP -> RECV -> DONE)
//   GAP: tx=1 for GAP_BITS*BAUD_PERIOD cycles. With GAP_BITS=0, the next start bit
//   immediately follows the stop bit.
//   DONE: rsp_valid=1 for one cycle, then IDLE. For writes, DONE is the cycle after the
//   data stop bit ends. rsp_rdata and rsp_err hold until the next rsp_valid.
//  Read reply: rx is double-flop synchronised; the synchroniser adds 2 cycles of latency.
//   WAIT_RSP starts the timeout counter at the end of the addr stop bit. A synchronised
//   rx falling edge enters RECV. Each bit is sampled at BAUD_PERIOD/2 cycles into its bit
//   time. Start bit re-checked at mid-bit: if high, treat it as a glitch and return to
//   WAIT_RSP (timeout counter keeps running).
//   After the stop-bit sample, go to DONE: rsp_rdata = payload[DATA_WIDTH-1:0];
//   stop bit = 0 -> rsp_err=1, rsp_rdata=0.
//   Timeout (TIMEOUT_CYC cycles with no start bit): DONE with rsp_err=1, rsp_rdata=0.
//  rx activity outside WAIT_RSP/RECV is ignored.
//  No new request is accepted before rsp_valid. Back-to-back: req_ready rises the cycle
//   after rsp_valid.
//  Reset mid-operation: tx forced to 1 asynchronously. Any partial frame is abandoned.
//   No rsp_valid for the aborted request.
// TESTING (ADDR_WIDTH=8, DATA_WIDTH=4, BAUD_PERIOD=4, GAP_BITS=2)
//  Write addr=0x05 data=0xA -> tx frames 0x01,0x05,0x0A; each 40 cycles, 8-cycle gaps;
//   rsp_valid at cycle 137 after accept, rsp_err=0.
//  Read addr=0x05, bench returns frame 0x0A on rx 10 cycles after the addr stop bit ->
//   tx frames 0x00,0x05; rsp_rdata=0xA, rsp_err=0.
//  Read with rx held high -> rsp_valid exactly TIMEOUT_CYC cycles after the addr stop bit;
//   rsp_err=1, rsp_rdata=0.
//  Read reply with stop bit=0 -> rsp_err=1, rsp_rdata=0. 1-cycle rx low pulse before the
//   real reply -> ignored; correct data returned.
//  Loopback with the target memory: write 0x3 to addr 2, then read addr 2 -> rsp_rdata=0x3.
//   req_valid held during a transfer -> req_ready=0 until the cycle after rsp_valid.
//  rst_l asserted mid SEND_ADDR -> tx=1 same cycle, no rsp_valid. After release, a fresh
//   write completes normally.

Source files
------------

// File: rtl/uart_mem_host_if.sv
// Request/response port of the UART memory host: valid/ready request in, one-cycle response strobe out.
interface uart_mem_host_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/uart_mem_host.sv
// Serialises read/write requests into UART frames on tx and collects the read reply from rx.
// One request in flight: req_ready only in IDLE; write completes 137 cycles after accept at defaults.
module uart_mem_host #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 4,
    parameter int BAUD_PERIOD = 4,
    parameter int GAP_BITS    = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic            clk,
    input  logic            rst_l,
    uart_mem_host_if.slave  bus,
    output logic            tx,
    input  logic            rx
);
    if (DATA_WIDTH > ADDR_WIDTH) begin : g_dw_chk
        $fatal(1, "DATA_WIDTH must not exceed ADDR_WIDTH");
    end
    if (BAUD_PERIOD < 2) begin : g_bp_chk
        $fatal(1, "BAUD_PERIOD must be at least 2");
    end

    localparam int GAP_CYC = GAP_BITS * BAUD_PERIOD;
    localparam int CNT_MAX = (GAP_CYC > BAUD_PERIOD) ? GAP_CYC : BAUD_PERIOD;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(ADDR_WIDTH + 2);
    localparam int TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_PERIOD - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CW-1:0] MID       = CW'(BAUD_PERIOD / 2);
    localparam logic [BW-1:0] STOP_IDX  = BW'(ADDR_WIDTH + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        IDLE, SEND_CMD, GAP_A, SEND_ADDR, GAP_D, SEND_DATA, WAIT_RSP, RECV, DONE
    } state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [BW-1:0]         bit_idx, bit_n;
    logic [TW-1:0]         tmo, tmo_n;
    logic [ADDR_WIDTH-1:0] tx_sh, tx_sh_n;
    logic [ADDR_WIDTH-1:0] rx_sh, rx_sh_n;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_n;
    logic                  err_q, err_n;
    logic                  cap_write;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic                  rx_s1, rx_s2, rx_d;
    logic                  rx_fall;
    logic                  frame_end;

    assign rx_fall       = rx_d & ~rx_s2;
    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = ~bus.req_ready;
    assign bus.rsp_valid = (state == DONE);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    // tx is decoded from state so reset forces the line idle without waiting for a clock
    always_comb begin
        tx = 1'b1;
        if (state == SEND_CMD || state == SEND_ADDR || state == SEND_DATA) begin
            if (bit_idx == '0)
                tx = 1'b0;
            else if (bit_idx != STOP_IDX)
                tx = tx_sh[0];
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_n     = bit_idx;
        tmo_n     = tmo;
        tx_sh_n   = tx_sh;
        rx_sh_n   = rx_sh;
        rdata_n   = rdata_q;
        err_n     = err_q;
        frame_end = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    state_n = SEND_CMD;
                    cnt_n   = '0;
                    bit_n   = '0;
                    tx_sh_n = ADDR_WIDTH'(bus.req_write);
                end
            end
            SEND_CMD, SEND_ADDR, SEND_DATA: begin
                if (cnt == BAUD_LAST) begin
                    cnt_n = '0;
                    if (bit_idx == STOP_IDX) begin
                        frame_end = 1'b1;
                        bit_n     = '0;
                    end else begin
                        bit_n = bit_idx + BW'(1);
                        if (bit_idx != '0)
                            tx_sh_n = tx_sh >> 1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
                if (frame_end) begin
                    if (state == SEND_CMD) begin
                        if (GAP_BITS == 0) begin
                            state_n = SEND_ADDR;
                            tx_sh_n = cap_addr;
                        end else begin
                            state_n = GAP_A;
                        end
                    end else if (state == SEND_ADDR && cap_write) begin
                        if (GAP_BITS == 0) begin
                            state_n = SEND_DATA;
                            tx_sh_n = ADDR_WIDTH'(cap_wdata);
                        end else begin
                            state_n = GAP_D;
                        end
                    end else if (state == SEND_ADDR) begin
                        state_n = WAIT_RSP;
                        tmo_n   = '0;
                    end else begin
                        state_n = DONE;
                        rdata_n = '0;
                        err_n   = 1'b0;
                    end
                end
            end
            GAP_A, GAP_D: begin
                if (cnt == GAP_LAST) begin
                    cnt_n = '0;
                    bit_n = '0;
                    if (state == GAP_A) begin
                        state_n = SEND_ADDR;
                        tx_sh_n = cap_addr;
                    end else begin
                        state_n = SEND_DATA;
                        tx_sh_n = ADDR_WIDTH'(cap_wdata);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WAIT_RSP: begin
                if (tmo != TMO_LAST)
                    tmo_n = tmo + TW'(1);
                // The edge-detect cycle is offset 0 of the start bit, so RECV begins at offset 1
                if (rx_fall) begin
                    state_n = RECV;
                    cnt_n   = CW'(1);
                    bit_n   = '0;
                end else if (tmo == TMO_LAST) begin
                    state_n = DONE;
                    rdata_n = '0;
                    err_n   = 1'b1;
                end
            end
            RECV: begin
                if (tmo != TMO_LAST)
                    tmo_n = tmo + TW'(1);
                if (cnt == BAUD_LAST) begin
                    cnt_n = '0;
                    bit_n = bit_idx + BW'(1);
                end else begin
                    cnt_n = cnt + CW'(1);
                end
                if (cnt == MID) begin
                    if (bit_idx == '0) begin
                        if (rx_s2)
                            state_n = WAIT_RSP;
                    end else if (bit_idx == STOP_IDX) begin
                        state_n = DONE;
                        err_n   = ~rx_s2;
                        rdata_n = rx_s2 ? rx_sh[DATA_WIDTH-1:0] : '0;
                    end else begin
                        rx_sh_n = {rx_s2, rx_sh[ADDR_WIDTH-1:1]};
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            tmo       <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_d      <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            tmo     <= tmo_n;
            tx_sh   <= tx_sh_n;
            rx_sh   <= rx_sh_n;
            rdata_q <= rdata_n;
            err_q   <= err_n;
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_d    <= rx_s2;
            if (state == IDLE && bus.req_valid) begin
                cap_write <= bus.req_write;
                cap_addr  <= bus.req_addr;
                cap_wdata <= bus.req_wdata;
            end
        end
    end
endmodule
